alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Iterative multiply/divide unit sitting beside the ALU in the execute stage; consumes the same in1/in2 operand buses.
- Serves MIPS mult/multu/div/divu and mthi/mtlo, holding results in HI/LO registers that mfhi/mflo read.
- Multi-cycle; asserts busy so the control unit stalls the PC until done.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  launch operation; sampled only in IDLE
- op  input  2  00 mult, 01 multu, 10 div, 11 divu
- in1  input  WIDTH  multiplicand / dividend (rs)
- in2  input  WIDTH  multiplier / divisor (rt)
- hi_we  input  1  mthi write enable
- lo_we  input  1  mtlo write enable
- wdata  input  WIDTH  mthi/mtlo data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO updated by an operation
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- One clock, clk; reset is synchronous and active-high. On reset: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation aborts; no partial result written.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE: if start=1 at edge N, latch op and the magnitudes of in1/in2 (signed ops: two's-complement absolute value; unsigned ops: raw), record result signs, clear the 64-bit accumulator, set counter=0, go to RUN. busy=1 from after edge N.
- RUN: one iteration per edge for 32 edges (N+1..N+32).
  - mult: shift-add, one multiplier bit per cycle.
  - div: restoring division, one quotient bit per cycle.
  - Go to FIX after counter reaches 31.
- FIX, edge N+33: apply sign correction and write HI/LO; done=1 and busy=0 in the following cycle; return to IDLE.
- Total latency: start edge to results visible is 33 edges.
- Mult results: HI = product[63:32], LO = product[31:0]. Signed product is negated if the operand signs differ.
- Div results: LO = quotient, HI = remainder. Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- Divide by zero: HI=in1 (as given), LO=0xFFFFFFFF, same 33-edge latency.
- Signed 0x80000000 / -1: LO=0x80000000, HI=0.
- start while busy: ignored.
- hi_we/lo_we: honoured only in IDLE, applied at the edge and visible next cycle; ignored while busy. If start and hi_we/lo_we are both asserted in IDLE, start wins and the write is dropped.
- hi/lo hold their value during RUN; they change only at the FIX edge, on mthi/mtlo, or on reset.
- done is never asserted for mthi/mtlo.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: for mult/multu, when the remaining unshifted multiplier bits are all zero, the block skips the remaining RUN iterations (aligning the accumulator) and goes to FIX at the next edge. Latency is then 2 + (index of highest set bit of |in2| + 1) edges, minimum 2 for in2=0. Division is unaffected.
- Undefined: latency is always 33 edges.

Decomposition:
- Package muldiv_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - state enum (S_IDLE, S_RUN, S_FIX)
  - WIDTH default
  - DIV0_LO constant 0xFFFFFFFF
- One natural sub-module: muldiv_abs, a combinational conditional negate used for operand magnitudes and result sign fix. The FSM and datapath stay in alu_muldiv.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done pulses exactly 33 edges after start; busy high throughout.
- mult 0xFFFFFFFD (-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; mult 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- div 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7 / 2 -> LO=3, HI=1.
- divu 7 / 0 -> HI=7, LO=0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Pulse start at cycle 10 of a running divide -> ignored, first result unchanged. hi_we with wdata=0x1234 while busy -> hi unchanged. Assert reset at cycle 20 -> busy=0, hi=lo=0 next cycle, no done.
- With MULDIV_EARLY_TERM_EN: multu 3 x 1 -> LO=3, HI=0 with done after 3 edges; without the macro -> 33 edges.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    // LO value written on divide by zero
    localparam logic [WIDTH_DEF-1:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_abs.sv
// Combinational conditional two's-complement negate (magnitude / sign fix).
module muldiv_abs #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res_c
);

    // Negate when requested, pass through otherwise
    assign res_c = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers (MIPS mult/div/mthi/mtlo).
// Optional build macro MULDIV_EARLY_TERM_EN: multiplies finish early once the
// remaining multiplier bits are all zero; division always takes the full count.
module alu_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned W2    = 2 * WIDTH;
    localparam logic [WIDTH-1:0] DIV0_VAL = {WIDTH{DIV0_LO[0]}};

    state_e state, state_next;
    logic   busy_next, done_next;

    logic             is_div_q;
    logic             res_neg_q;
    logic             rem_neg_q;
    logic [W2-1:0]    acc;
    logic [W2-1:0]    mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [CNT_W-1:0] cnt;

    logic             is_signed_c, is_div_c;
    logic             neg_a_c, neg_b_c;
    logic [WIDTH-1:0] abs_a_c, abs_b_c;
    logic [W2-1:0]    prod_fix_c;
    logic [WIDTH-1:0] quot_fix_c, rem_fix_c;
    logic             early_c;

    logic [W2-1:0]    acc_step;
    logic [W2-1:0]    mag_a_step;
    logic [WIDTH-1:0] mag_b_step;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

    // Operand decode and sign capture
    assign is_signed_c = (op == OP_MULT) || (op == OP_DIV);
    assign is_div_c    = (op == OP_DIV)  || (op == OP_DIVU);
    assign neg_a_c     = is_signed_c & in1[WIDTH-1];
    assign neg_b_c     = is_signed_c & in2[WIDTH-1];

    muldiv_abs #(.W(WIDTH)) u_abs_a (.val(in1), .neg(neg_a_c), .res_c(abs_a_c));
    muldiv_abs #(.W(WIDTH)) u_abs_b (.val(in2), .neg(neg_b_c), .res_c(abs_b_c));

    // Result sign correction: product, quotient, remainder
    muldiv_abs #(.W(W2))    u_fix_prod (.val(acc),              .neg(res_neg_q), .res_c(prod_fix_c));
    muldiv_abs #(.W(WIDTH)) u_fix_quot (.val(acc[WIDTH-1:0]),   .neg(res_neg_q), .res_c(quot_fix_c));
    muldiv_abs #(.W(WIDTH)) u_fix_rem  (.val(acc[W2-1:WIDTH]),  .neg(rem_neg_q), .res_c(rem_fix_c));

`ifdef MULDIV_EARLY_TERM_EN
    // Multiply may stop once no multiplier bits remain to be consumed
    assign early_c = !is_div_q && (mag_b == '0);
`else
    assign early_c = 1'b0;
`endif

    // One iteration: shift-add multiply or one restoring-division quotient bit
    always_comb begin
        acc_step   = acc;
        mag_a_step = mag_a << 1;
        mag_b_step = mag_b >> 1;
        rem_sh     = {acc[W2-1:WIDTH], mag_a[WIDTH-1]};
        trial      = rem_sh - {1'b0, mag_b};
        if (is_div_q) begin
            mag_b_step = mag_b;
            if (!trial[WIDTH]) begin
                acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else if (mag_b[0]) begin
            acc_step = acc + mag_a;
        end
    end

    // State and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_next = state;
        busy_next  = busy;
        done_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                    busy_next  = 1'b1;
                end
            end
            S_RUN: begin
                if (early_c || (cnt == CNT_W'(WIDTH - 1))) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // Datapath: operand latch, iteration, HI/LO write-back and mthi/mtlo
    always_ff @(posedge clk) begin
        if (reset) begin
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            acc       <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div_q  <= is_div_c;
                        res_neg_q <= neg_a_c ^ neg_b_c;
                        rem_neg_q <= neg_a_c;
                        acc       <= '0;
                        mag_a     <= W2'(abs_a_c);
                        mag_b     <= abs_b_c;
                        cnt       <= '0;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                S_RUN: begin
                    if (!early_c) begin
                        acc   <= acc_step;
                        mag_a <= mag_a_step;
                        mag_b <= mag_b_step;
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (is_div_q) begin
                        // Divisor held unchanged through RUN, so zero here means divide by zero
                        lo <= (mag_b == '0) ? DIV0_VAL : quot_fix_c;
                        hi <= rem_fix_c;
                    end else begin
                        hi <= prod_fix_c[W2-1:WIDTH];
                        lo <= prod_fix_c[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] in1, in2;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation and follow it until done (bounded); optional mid-run disturbance
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int elat, input bit disturb);
        logic [31:0] h0, l0;
        int          lat;
        bit          hold_ok;
        @(negedge clk);
        h0 = hi; l0 = lo;
        op = o; in1 = a; in2 = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        lat     = -1;
        hold_ok = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (!busy || hi !== h0 || lo !== l0) hold_ok = 1'b0;
            if (disturb && k == 10) begin
                start = 1'b1; op = 2'b00; in1 = 32'h5; in2 = 32'h5;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " busy/hold"}, 64'(hold_ok), 64'd1);
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " lo"}, 64'(lo), 64'(el));
        @(posedge clk);
        @(negedge clk);
        check({tag, " done pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int  et_lat;
        bit  saw_done;
        reset = 1'b1; start = 1'b0; op = 2'b00; in1 = '0; in2 = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);

        // mthi / mtlo in IDLE
        hi_we = 1'b1; wdata = 32'hAAAA_5555;
        @(posedge clk); @(negedge clk);
        hi_we = 1'b0;
        check("mthi hi", 64'(hi), 64'hAAAA_5555);
        check("mthi no done", 64'(done), 64'd0);
        lo_we = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        lo_we = 1'b0;
        check("mtlo lo", 64'(lo), 64'h1234_5678);
        check("mthi hi kept", 64'(hi), 64'hAAAA_5555);

        run_op("multu max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
        run_op("mult -3x5",  2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 1'b0);
        run_op("mult min^2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33, 1'b0);
        run_op("div -7/2",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("div 7/-2",   2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("divu 7/2",   2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 33, 1'b0);
        run_op("divu 7/0",   2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1'b0);
        run_op("divu dist",  2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        33, 1'b1);

`ifdef MULDIV_EARLY_TERM_EN
        et_lat = 3;
`else
        et_lat = 33;
`endif
        run_op("multu 3x1",  2'b01, 32'd3, 32'd1, 32'd0, 32'd3, et_lat, 1'b0);

        // Reset in the middle of a divide
        @(negedge clk);
        op = 2'b11; in1 = 32'd1000; in2 = 32'd3; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst hi", 64'(hi), 64'd0);
        check("midrst lo", 64'(lo), 64'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done || busy) saw_done = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        check("midrst quiet", 64'(saw_done), 64'd0);
        check("midrst lo kept", 64'(lo), 64'd0);

        run_op("post-rst divu", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 33, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
